// File: rtl/spi_dac_receiver.sv
// SPI receiver for an emulated DAC: synchronizes the SPI pins into clock_in, frames words on cs_n.
// Optional macro SPI_RX_LDAC_EN: dac_value follows the input register while ldac is low.
module spi_dac_receiver #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock_in,
   input  logic             reset_in,
   input  logic             sclk_in,
   input  logic             mosi_in,
   input  logic             cs_in,
   input  logic             ldac_in,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic [WIDTH-1:0] dac_value,
   output logic             frame_error,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_OVER = CW'(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      OVERRUN = 2'd2
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic sclk_s, mosi_s, cs_s;
   logic sclk_d, cs_d;
   logic sclk_rise, cs_rise;
   logic armed;

   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic [WIDTH-1:0] in_reg;
   logic             load_word, load_err;

   // SYNC_STAGES must be at least 2; stage [SYNC_STAGES-1] is the synchronized copy.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_d      <= 1'b0;
         cs_d        <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
         sclk_d      <= sclk_s;
         cs_d        <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign cs_rise   = cs_s & ~cs_d;

   // Synchronizers clear to 0, which looks like an asserted cs; a frame may only
   // start once cs has been seen high after reset.
   always_ff @(posedge clock_in) begin
      if (reset_in)  armed <= 1'b0;
      else if (cs_s) armed <= 1'b1;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         shreg <= shreg_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      shreg_next = shreg;
      load_word  = 1'b0;
      load_err   = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !cs_s) begin
               state_next = SHIFT;
               cnt_next   = '0;
               shreg_next = '0;
               if (sclk_rise) begin
                  shreg_next[0] = mosi_s;
                  cnt_next      = CW'(1);
               end
            end
         end
         SHIFT: begin
            // cs rise takes priority over a coincident sclk rise.
            if (cs_rise) begin
               state_next = IDLE;
               if (cnt == CNT_FULL) load_word = 1'b1;
               else                 load_err  = 1'b1;
            end else if (sclk_rise) begin
               if (cnt == CNT_FULL) begin
                  state_next = OVERRUN;
                  cnt_next   = CNT_OVER;
               end else begin
                  shreg_next = {shreg[WIDTH-2:0], mosi_s};
                  cnt_next   = cnt + CW'(1);
               end
            end
         end
         OVERRUN: begin
            if (cs_rise) begin
               state_next = IDLE;
               load_err   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign state_dbg = state;

   // word_valid and frame_error are single-cycle pulses with no back-pressure;
   // they come from mutually exclusive branches and can never coincide.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         word_out    <= '0;
         in_reg      <= '0;
         word_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         word_valid  <= load_word;
         frame_error <= load_err;
         if (load_word) begin
            word_out <= shreg;
            in_reg   <= shreg;
         end
      end
   end

`ifdef SPI_RX_LDAC_EN
   logic [SYNC_STAGES-1:0] ldac_sync_q;
   logic ldac_s;

   always_ff @(posedge clock_in) begin
      if (reset_in) ldac_sync_q <= '0;
      else          ldac_sync_q <= {ldac_sync_q[SYNC_STAGES-2:0], ldac_in};
   end

   assign ldac_s = ldac_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock_in) begin
      if (reset_in)     dac_value <= '0;
      else if (!ldac_s) dac_value <= in_reg;
   end
`else
   logic ldac_unused;
   assign ldac_unused = ldac_in;

   // Without LDAC the DAC register is the input register itself.
   assign dac_value = in_reg;
`endif

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Randomized bench for spi_dac_receiver with a bit-queue reference model of each frame.
// Honors SPI_RX_LDAC_EN if defined for the DAC-register expectations.
module tb_spi_dac_receiver;

   localparam int W  = 16;
   localparam int SS = 2;

   logic         clock_in = 1'b0;
   logic         reset_in, sclk_in, mosi_in, cs_in, ldac_in;
   logic [W-1:0] word_out, dac_value;
   logic         word_valid, frame_error;
   logic [1:0]   state_dbg;

   spi_dac_receiver #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clock_in   (clock_in),
      .reset_in   (reset_in),
      .sclk_in    (sclk_in),
      .mosi_in    (mosi_in),
      .cs_in      (cs_in),
      .ldac_in    (ldac_in),
      .word_out   (word_out),
      .word_valid (word_valid),
      .dac_value  (dac_value),
      .frame_error(frame_error),
      .state_dbg  (state_dbg)
   );

   // clock / reset block
   always #5 clock_in = ~clock_in;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // pulse monitor
   int   wv_cnt = 0;
   int   fe_cnt = 0;
   logic both_seen = 1'b0;
   always @(negedge clock_in) begin
      if (word_valid === 1'b1)  wv_cnt++;
      if (frame_error === 1'b1) fe_cnt++;
      if (word_valid === 1'b1 && frame_error === 1'b1) both_seen = 1'b1;
   end

   // reference model
   logic         sent_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] model_word = '0;
   logic [W-1:0] model_dac  = '0;
   bit           cs_is_low  = 1'b0;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic cs_low();
      if (!cs_is_low) begin
         cs_in = 1'b0;
         wait_clks(4);
      end
      cs_is_low = 1'b0;
   endtask

   // sclk = clock/8
   task automatic send_bit(input logic b);
      mosi_in = b;
      sclk_in = 1'b0;
      wait_clks(4);
      sclk_in = 1'b1;
      wait_clks(4);
      sent_q.push_back(b);
   endtask

   task automatic end_frame(input bit coincident, input int gap, input string tag);
      int           n, wv0, fe0;
      bit           good;
      logic [W-1:0] word, exp;
      sclk_in = 1'b0;
      wait_clks(4);
      n    = sent_q.size();
      good = (n == W);
      word = '0;
      foreach (sent_q[i]) word = {word[W-2:0], sent_q[i]};
      if (good) begin
         exp_q.push_back(word);
         model_word = word;
`ifndef SPI_RX_LDAC_EN
         model_dac = word;
`endif
      end
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      if (coincident) begin
         sclk_in = 1'b1;
         mosi_in = 1'($urandom_range(0, 1));
      end
      cs_in = 1'b1;
      for (int i = 1; i <= SS + 1; i++) begin
         @(negedge clock_in);
         if (i == gap) begin
            cs_in     = 1'b0;
            cs_is_low = 1'b1;
         end
      end
      check({tag, "_valid_latency"}, word_valid, good);
      check({tag, "_error_latency"}, frame_error, !good);
      if (good) begin
         exp = exp_q.pop_front();
         check({tag, "_word_at_pulse"}, word_out, exp);
`ifndef SPI_RX_LDAC_EN
         check({tag, "_dac_at_pulse"}, dac_value, exp);
`endif
      end
      wait_clks(6);
      sclk_in = 1'b0;
      check({tag, "_valid_count"}, wv_cnt - wv0, good);
      check({tag, "_error_count"}, fe_cnt - fe0, !good);
      check({tag, "_word_hold"}, word_out, model_word);
      check({tag, "_dac"}, dac_value, model_dac);
      check({tag, "_state_after"}, state_dbg, cs_is_low ? 2'd1 : 2'd0);
   endtask

   task automatic send_frame(input logic [31:0] data, input int n, input bit coincident,
                             input int gap, input string tag);
      sent_q.delete();
      cs_low();
      for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
      check({tag, "_state_in_frame"}, state_dbg, (n > W) ? 2'd2 : 2'd1);
      end_frame(coincident, gap, tag);
   endtask

`ifdef SPI_RX_LDAC_EN
   task automatic pulse_ldac(input string tag);
      ldac_in = 1'b0;
      wait_clks(8);
      model_dac = model_word;
      ldac_in = 1'b1;
      wait_clks(4);
      check({tag, "_dac_after_ldac"}, dac_value, model_dac);
   endtask
`endif

   initial begin
      int          wv0, fe0, n, r;
      logic [31:0] data;
      reset_in = 1'b1;
      sclk_in  = 1'b0;
      mosi_in  = 1'b0;
      cs_in    = 1'b1;
      ldac_in  = 1'b1;
      wait_clks(5);
      check("rst_word", word_out, 0);
      check("rst_dac", dac_value, 0);
      check("rst_valid", word_valid, 0);
      check("rst_error", frame_error, 0);
      check("rst_state", state_dbg, 0);
      reset_in = 1'b0;
      wait_clks(5);

      // nominal frame, then LDAC if present
      send_frame(32'hA5C3, W, 1'b0, 0, "a5c3");
`ifdef SPI_RX_LDAC_EN
      pulse_ldac("a5c3");
`endif

      // short and long frames
      send_frame(32'h1ABC, W - 1, 1'b0, 0, "short15");
      send_frame(32'h1_5A5A, W + 1, 1'b0, 0, "long17");

      // back-to-back with cs high for two clocks
      send_frame(32'h0001, W, 1'b0, 2, "b2b_first");
      send_frame(32'hFFFF, W, 1'b0, 0, "b2b_second");

      // reset in the middle of a frame
      sent_q.delete();
      cs_low();
      for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
      reset_in = 1'b1;
      wait_clks(3);
      check("midrst_word", word_out, 0);
      check("midrst_dac", dac_value, 0);
      check("midrst_valid", word_valid, 0);
      check("midrst_error", frame_error, 0);
      model_word = '0;
      model_dac  = '0;
      reset_in   = 1'b0;
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
      check("midrst_state_ignored", state_dbg, 0);
      sclk_in = 1'b0;
      wait_clks(4);
      cs_in = 1'b1;
      wait_clks(10);
      check("midrst_no_valid", wv_cnt - wv0, 0);
      check("midrst_no_error", fe_cnt - fe0, 0);
      check("midrst_word_hold", word_out, 0);
      send_frame(32'h1234, W, 1'b0, 0, "after_rst");

      // sclk rise coincident with cs rise
      send_frame(32'hC0DE, W, 1'b1, 0, "coincident");
      send_frame(32'h7FFF, W, 1'b0, 0, "x7fff");

      // randomized frames
      for (int k = 0; k < 20; k++) begin
         r = $urandom_range(0, 4);
         case (r)
            0, 1:    n = W;
            2:       n = W - 1;
            3:       n = W + 1;
            default: n = $urandom_range(1, W + 3);
         endcase
         data = $urandom();
         send_frame(data, n, ($urandom_range(0, 3) == 0), 0, $sformatf("rand%0d", k));
`ifdef SPI_RX_LDAC_EN
         if ($urandom_range(0, 2) == 0) pulse_ldac($sformatf("rand%0d", k));
`endif
      end

      check("never_both_pulses", both_seen, 0);
      check("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
